window_ctrl_multi: RTL and testbench
====================================

# window_ctrl_multi

Parametrised multi-channel power-window controller: the next generation of the single-button window FSM. It drives CHANNELS independent windows, each with separate up/down buttons, one-touch (auto) versus hold-to-run (manual) travel, a position counter with end-stop detection, and obstruction (anti-pinch) reversal. It sits between the synchronised/debounced button and sensor inputs and the motor driver outputs in the window subsystem.

## Interface
- CHANNELS, 4, number of independent windows
- POS_W, 8, position counter width per channel
- TRAVEL, 200, full-travel position in motor cycles; must satisfy 1 ≤ TRAVEL < 2^POS_W
- AUTO_HOLD, 8, hold cycles in pending state that select manual mode; ≥ 2
- REVERSE_CYCLES, 16, motor_down cycles after an obstruction; ≥ 1

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all channels
- up_btn  input  CHANNELS  level, already synchronised/debounced, bit i = channel i
- down_btn  input  CHANNELS  level, same rules as up_btn
- obstruct  input  CHANNELS  pinch sensor, level, synchronous
- motor_up  output  CHANNELS  drive window closed
- motor_down  output  CHANNELS  drive window open
- position  output  CHANNELS*POS_W  channel i at bits [i*POS_W +: POS_W]; 0 = fully open
- at_top  output  CHANNELS  position == TRAVEL
- at_bottom  output  CHANNELS  position == 0

## Operation
- Channels are fully independent; each has a state register, hold counter and position counter.
- States: IDLE, UP_PEND, UP_MAN, UP_AUTO, DN_PEND, DN_MAN, DN_AUTO, REVERSE.
- motor_up = 1 in UP_*; motor_down = 1 in DN_* and REVERSE. Never both high.
- IDLE: up only and !at_top → UP_PEND; down only and !at_bottom → DN_PEND; both, neither, or a press toward the end stop already reached → IDLE. The hold counter clears on PEND entry.
- x_PEND: button held → hold counter +1; when AUTO_HOLD consecutive held cycles have been counted → x_MAN. Button released earlier → x_AUTO.
- x_MAN: button released → IDLE.
- x_AUTO: any up_btn or down_btn high → IDLE (stop). Otherwise run to end stop.
- Both buttons high in any PEND/MAN state → IDLE.
- Position: on every edge where the current state drives the motor, position ±1. End stop: the edge that makes position TRAVEL (up) or 0 (down) also forces IDLE, so the motor is never asserted at the end stop.
- Obstruction: obstruct high in any UP_* state → REVERSE, counter loaded with REVERSE_CYCLES. Obstruct is ignored in DN_*, IDLE and REVERSE.
- REVERSE: buttons are ignored. Counter decrements each cycle; → IDLE when it reaches 0 or position reaches 0, whichever is first.
- Priority per channel: reset > end stop > obstruction > both-buttons stop > normal transitions.

## Timing
- Reset (asynchronous): all channels IDLE, position 0, counters 0, motor_up = motor_down = 0, at_bottom = all ones, at_top = 0. A reset mid-travel stops the motors immediately and loses position.
- All outputs are registered or decoded from registers only; no combinational path from input to output.
- Latency: a press sampled at edge k asserts the motor after edge k; motion ends after the edge that samples release, stop, or end stop.
- Position equals the number of cycles the motor was asserted, saturating at TRAVEL and at 0.
- Tap: button high for fewer than AUTO_HOLD sampled edges → auto. Exactly AUTO_HOLD edges or more → manual.

## Test plan
Bench parameters: CHANNELS=2, TRAVEL=20, AUTO_HOLD=4, REVERSE_CYCLES=5.
- Tap up_btn[0] for 2 cycles from reset → motor_up[0] high for exactly 20 cycles; position[0]=20 and at_top[0]=1; channel 1 stays at 0.
- Hold up_btn[0] for 10 cycles → UP_MAN; motor_up high for 10 cycles; position 10. Then hold down_btn for 3 cycles → DN_AUTO; runs to 0; at_bottom=1.
- During an auto-up at position 12, pulse obstruct[0] for 1 cycle → motor_down for 5 cycles; position 7, then IDLE; buttons pressed during REVERSE have no effect.
- Reverse near bottom: obstruct at position 2 → motor_down for 2 cycles; position 0; IDLE.
- Edge cases: up and down pressed together in IDLE → no motion; up pressed at position 20 → no motion; a press during auto-up at position 8 → stop at position 9.
- Assert reset mid-travel at position 6 → motors low immediately; position 0; a subsequent tap behaves as in the first scenario.

Source files
------------

// File: rtl/window_ctrl_multi.sv
// Multi-channel power-window controller: per-channel up/down buttons, one-touch vs
// hold-to-run travel, position tracking with end stops, and anti-pinch reversal.
//
// state   | meaning
// IDLE    | motor off, waiting for a single-button press
// UP_PEND | driving up, counting hold cycles to choose auto/manual
// UP_MAN  | hold-to-run closing until button released
// UP_AUTO | one-touch closing until top or any button
// DN_PEND | driving down, counting hold cycles to choose auto/manual
// DN_MAN  | hold-to-run opening until button released
// DN_AUTO | one-touch opening until bottom or any button
// REVERSE | obstruction backoff, buttons ignored
module window_ctrl_multi #(
    parameter int CHANNELS       = 4,
    parameter int POS_W          = 8,
    parameter int TRAVEL         = 200,
    parameter int AUTO_HOLD      = 8,
    parameter int REVERSE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       up_btn,
    input  logic [CHANNELS-1:0]       down_btn,
    input  logic [CHANNELS-1:0]       obstruct,
    output logic [CHANNELS-1:0]       motor_up,
    output logic [CHANNELS-1:0]       motor_down,
    output logic [CHANNELS*POS_W-1:0] position,
    output logic [CHANNELS-1:0]       at_top,
    output logic [CHANNELS-1:0]       at_bottom
);

    localparam int CNT_MAX = (AUTO_HOLD > REVERSE_CYCLES) ? AUTO_HOLD : REVERSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(AUTO_HOLD - 2);
    localparam logic [CNT_W-1:0] REV_LOAD  = CNT_W'(REVERSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, UP_PEND, UP_MAN, UP_AUTO, DN_PEND, DN_MAN, DN_AUTO, REVERSE
    } state_t;

    state_t           state_q [CHANNELS];
    state_t           state_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_d   [CNT_W > 0 ? CHANNELS : CHANNELS];
    logic [POS_W-1:0] pos_q   [CHANNELS];
    logic [POS_W-1:0] pos_d   [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
                pos_q[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                pos_q[ch]   <= pos_d[ch];
            end
        end
    end

    // Overrides are applied lowest priority first so the last assignment wins:
    // normal transitions < both-button stop < obstruction < end stop.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            logic up, dn, both, held, drive_up, drive_dn;
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            pos_d[ch]   = pos_q[ch];
            up       = up_btn[ch];
            dn       = down_btn[ch];
            both     = up & dn;
            drive_up = state_q[ch] inside {UP_PEND, UP_MAN, UP_AUTO};
            drive_dn = state_q[ch] inside {DN_PEND, DN_MAN, DN_AUTO, REVERSE};
            held     = drive_up ? up : dn;

            if (drive_up) pos_d[ch] = pos_q[ch] + POS_ONE;
            if (drive_dn) pos_d[ch] = pos_q[ch] - POS_ONE;

            case (state_q[ch])
                IDLE: begin
                    if (up && !dn && pos_q[ch] != POS_TOP) begin
                        state_d[ch] = UP_PEND;
                        cnt_d[ch]   = '0;
                    end else if (dn && !up && pos_q[ch] != '0) begin
                        state_d[ch] = DN_PEND;
                        cnt_d[ch]   = '0;
                    end
                end
                UP_PEND, DN_PEND: begin
                    // The IDLE edge already sampled one held cycle, hence AUTO_HOLD-2.
                    if (held) begin
                        if (cnt_q[ch] == HOLD_LAST)
                            state_d[ch] = (state_q[ch] == UP_PEND) ? UP_MAN : DN_MAN;
                        else
                            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end else begin
                        state_d[ch] = (state_q[ch] == UP_PEND) ? UP_AUTO : DN_AUTO;
                    end
                end
                UP_MAN, DN_MAN: begin
                    if (!held) state_d[ch] = IDLE;
                end
                UP_AUTO, DN_AUTO: begin
                    if (up || dn) state_d[ch] = IDLE;
                end
                REVERSE: begin
                    cnt_d[ch] = cnt_q[ch] - CNT_ONE;
                    if (cnt_q[ch] == CNT_ONE) state_d[ch] = IDLE;
                end
                default: state_d[ch] = IDLE;
            endcase

            if (both && state_q[ch] inside {UP_PEND, UP_MAN, DN_PEND, DN_MAN})
                state_d[ch] = IDLE;

            if (drive_up && obstruct[ch]) begin
                state_d[ch] = REVERSE;
                cnt_d[ch]   = REV_LOAD;
            end

            if ((drive_up && pos_q[ch] == POS_TOP - POS_ONE) ||
                (drive_dn && pos_q[ch] == POS_ONE))
                state_d[ch] = IDLE;
        end
    end

    always_comb begin
        motor_up   = '0;
        motor_down = '0;
        at_top     = '0;
        at_bottom  = '0;
        position   = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            motor_up[ch]   = state_q[ch] inside {UP_PEND, UP_MAN, UP_AUTO};
            motor_down[ch] = state_q[ch] inside {DN_PEND, DN_MAN, DN_AUTO, REVERSE};
            at_top[ch]     = (pos_q[ch] == POS_TOP);
            at_bottom[ch]  = (pos_q[ch] == '0);
            position[ch*POS_W +: POS_W] = pos_q[ch];
        end
    end

endmodule

// File: tb/tb_window_ctrl_multi.sv
// Scoreboard bench for window_ctrl_multi: channel 0 motion segments (direction,
// length, end position) are predicted by hand and checked by a negedge monitor.
module tb_window_ctrl_multi;

    localparam int CHANNELS = 2;
    localparam int POS_W    = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS-1:0]       up_btn, down_btn, obstruct;
    logic [CHANNELS-1:0]       motor_up, motor_down, at_top, at_bottom;
    logic [CHANNELS*POS_W-1:0] position;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       dir;   // 1 = up
        int         len;
        logic [7:0] pos;
    } seg_t;

    seg_t exp_q[$];

    window_ctrl_multi #(
        .CHANNELS(CHANNELS), .POS_W(POS_W), .TRAVEL(20),
        .AUTO_HOLD(4), .REVERSE_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset),
        .up_btn(up_btn), .down_btn(down_btn), .obstruct(obstruct),
        .motor_up(motor_up), .motor_down(motor_down),
        .position(position), .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: a segment ends when channel 0's motor drive changes away from active.
    logic [1:0] prev_drv = 2'b00;
    int         seg_len  = 0;
    always @(negedge clk) begin
        logic [1:0] cur;
        seg_t e;
        cur = {motor_up[0], motor_down[0]};
        checks++;
        if ((motor_up & motor_down) != '0) begin
            fails++;
            $display("FAIL both_motors: up=%b down=%b, required no overlap", motor_up, motor_down);
        end
        if (prev_drv != 2'b00 && cur != prev_drv) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_segment: dir_up=%b len=%0d pos=%0d, none expected",
                         prev_drv[1], seg_len, position[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (prev_drv[1] !== e.dir || seg_len != e.len || position[7:0] !== e.pos) begin
                    fails++;
                    $display("FAIL segment: got dir_up=%b len=%0d pos=%0d, required dir_up=%b len=%0d pos=%0d",
                             prev_drv[1], seg_len, position[7:0], e.dir, e.len, e.pos);
                end
            end
            seg_len = 0;
        end
        if (cur != 2'b00) seg_len++;
        prev_drv = cur;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic push(input logic dir, input int len, input int pos);
        seg_t s;
        s.dir = dir; s.len = len; s.pos = pos[7:0];
        exp_q.push_back(s);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (((motor_up | motor_down) != '0) && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) check("wait_idle_timeout", n, 0);
        tick(1);
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        while (int'(position[7:0]) != target && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) check("wait_pos_timeout", int'(position[7:0]), target);
    endtask

    task automatic tap_up0();
        up_btn[0] = 1'b1; tick(2); up_btn[0] = 1'b0;
    endtask

    task automatic tap_dn0();
        down_btn[0] = 1'b1; tick(2); down_btn[0] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; up_btn = '0; down_btn = '0; obstruct = '0;
        tick(2);
        reset = 1'b0;
        check("rst_motor_up",   motor_up,   0);
        check("rst_motor_down", motor_down, 0);
        check("rst_position",   position,   0);
        check("rst_at_bottom",  at_bottom,  3);
        check("rst_at_top",     at_top,     0);

        // Tap (2 edges) -> auto up for the full travel.
        push(1'b1, 20, 20);
        tap_up0(); wait_idle();
        check("tap_pos0",     position[7:0],  20);
        check("tap_at_top0",  at_top[0],      1);
        check("tap_pos1",     position[15:8], 0);
        check("tap_at_bot1",  at_bottom[1],   1);

        // Up at the end stop: nothing moves.
        up_btn[0] = 1'b1; tick(3); up_btn[0] = 1'b0; tick(2);
        check("top_press_pos", position[7:0], 20);

        // Down held 3 edges -> auto down to bottom.
        push(1'b0, 20, 0);
        down_btn[0] = 1'b1; tick(3); down_btn[0] = 1'b0; wait_idle();
        check("auto_dn_bottom", at_bottom[0], 1);

        // Up held 10 edges -> manual, stops on release at 10.
        push(1'b1, 10, 10);
        up_btn[0] = 1'b1; tick(10); up_btn[0] = 1'b0; wait_idle();
        check("man_up_pos", position[7:0], 10);

        push(1'b0, 10, 0);
        down_btn[0] = 1'b1; tick(3); down_btn[0] = 1'b0; wait_idle();
        check("auto_dn2_bottom", at_bottom[0], 1);

        // Exactly AUTO_HOLD edges -> manual, 4 cycles of travel.
        push(1'b1, 4, 4);
        up_btn[0] = 1'b1; tick(4); up_btn[0] = 1'b0; wait_idle();
        check("hold4_pos", position[7:0], 4);
        push(1'b0, 4, 0);
        tap_dn0(); wait_idle();

        // Obstruction sampled on the edge that reaches 12 -> 5 cycles down to 7; buttons ignored.
        push(1'b1, 12, 12);
        push(1'b0, 5, 7);
        tap_up0(); wait_pos(11);
        obstruct[0] = 1'b1; tick(1); obstruct[0] = 1'b0;
        up_btn[0] = 1'b1; tick(2); up_btn[0] = 1'b0;
        down_btn[0] = 1'b1; tick(1); down_btn[0] = 1'b0;
        wait_idle();
        check("reverse_pos", position[7:0], 7);

        // Obstruct while opening is ignored.
        push(1'b0, 7, 0);
        tap_dn0();
        obstruct[0] = 1'b1; tick(1); obstruct[0] = 1'b0;
        wait_idle();
        check("dn_obstruct_pos", position[7:0], 0);

        // Reverse near bottom: obstruct on the edge reaching 2 -> 2 cycles down.
        push(1'b1, 2, 2);
        push(1'b0, 2, 0);
        up_btn[0] = 1'b1; tick(2);
        up_btn[0] = 1'b0; obstruct[0] = 1'b1; tick(1); obstruct[0] = 1'b0;
        wait_idle();
        check("rev_bottom_pos", position[7:0], 0);

        // Both buttons together in IDLE: no motion.
        up_btn = 2'b11; down_btn = 2'b11; tick(3);
        up_btn = '0; down_btn = '0; tick(2);
        check("both_pos", position, 0);

        // Press during auto-up at 8 stops at 9.
        push(1'b1, 9, 9);
        tap_up0(); wait_pos(8);
        up_btn[0] = 1'b1; tick(1); up_btn[0] = 1'b0;
        wait_idle();
        check("stop_pos", position[7:0], 9);
        push(1'b0, 9, 0);
        tap_dn0(); wait_idle();

        // Reset at position 6 stops immediately and loses position.
        push(1'b1, 6, 0);
        tap_up0(); wait_pos(6);
        reset = 1'b1; #1;
        check("rst_mid_motor", motor_up[0], 0);
        check("rst_mid_pos",   position[7:0], 0);
        tick(1); reset = 1'b0; tick(1);
        push(1'b1, 20, 20);
        tap_up0(); wait_idle();
        check("after_rst_top", at_top[0], 1);

        tick(3);
        check("ch1_final_pos", position[15:8], 0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
